// File: rtl/lsu_align_unit.sv
// Load/store alignment unit: shifts data onto byte lanes, builds byte enables,
// extends loads and optionally splits word-crossing accesses into two bus beats.
module lsu_align_unit #(
    parameter int XLEN             = 32,
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_fault,
    output logic              mem_read,
    output logic              mem_write,
    output logic [XLEN-1:0]   mem_address,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_byte_enable,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_resp
);

    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC0 = 2'd1;
    localparam logic [1:0] ACC1 = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]      state_q, state_d;
    logic            we_q, we_d;
    logic            uns_q, uns_d;
    logic [1:0]      sz_q, sz_d;
    logic [OFFW-1:0] off_q, off_d;
    logic [XLEN-1:0] base_q, base_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic            split_q, split_d;
    logic            fault_q, fault_d;
    logic            gap_q, gap_d;
    logic [XLEN-1:0] beat0_q, beat0_d;
    logic [XLEN-1:0] beat1_q, beat1_d;

    logic [3:0]         reqSize;
    logic               reqIllegal;
    logic               reqSplit;
    logic               reqFault;
    logic [3:0]         sizeBytes;
    logic [2*BYTES-1:0] maskBase;
    logic [2*BYTES-1:0] maskWide;
    logic [2*XLEN-1:0]  dataWide;
    logic [XLEN-1:0]    mergedLow;
    logic [XLEN-1:0]    lowMask;
    logic               signBit;
    logic [XLEN-1:0]    loadResult;

    always_comb begin
        reqSize    = 4'(1) << req_funct3[1:0];
        reqIllegal = (int'(req_funct3[1:0]) > OFFW) || (req_we && req_funct3[2]) ||
                     (req_funct3 == 3'b111);
        reqSplit   = (int'(req_addr[OFFW-1:0]) + int'(reqSize)) > BYTES;
        reqFault   = reqIllegal || (reqSplit && !SPLIT_MISALIGNED);
    end

    // Both beats come from one double-width shift: the low half lands in the
    // first word, whatever spills past the boundary lands in the second.
    always_comb begin
        sizeBytes = 4'(1) << sz_q;
        maskBase  = ((2*BYTES)'(1) << sizeBytes) - (2*BYTES)'(1);
        maskWide  = maskBase << off_q;
        dataWide  = {{XLEN{1'b0}}, wdata_q} << {off_q, 3'b000};
        mergedLow = XLEN'({beat1_q, beat0_q} >> {off_q, 3'b000});
        if (int'(sizeBytes) >= BYTES) begin
            lowMask = '1;
        end else begin
            lowMask = (XLEN'(1) << {sizeBytes, 3'b000}) - XLEN'(1);
        end
        signBit    = |(mergedLow & lowMask & ~(lowMask >> 1));
        loadResult = (mergedLow & lowMask) | ((signBit && !uns_q) ? ~lowMask : '0);
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        sz_d    = sz_q;
        off_d   = off_q;
        base_d  = base_q;
        wdata_d = wdata_q;
        split_d = split_q;
        fault_d = fault_q;
        gap_d   = gap_q;
        beat0_d = beat0_q;
        beat1_d = beat1_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    uns_d   = req_funct3[2];
                    sz_d    = req_funct3[1:0];
                    off_d   = req_addr[OFFW-1:0];
                    base_d  = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
                    wdata_d = req_wdata;
                    split_d = reqSplit;
                    fault_d = reqFault;
                    gap_d   = 1'b0;
                    state_d = reqFault ? DONE : ACC0;
                end
            end
            ACC0: begin
                if (mem_resp) begin
                    beat0_d = mem_rdata;
                    gap_d   = split_q;
                    state_d = split_q ? ACC1 : DONE;
                end
            end
            ACC1: begin
                // First ACC1 cycle keeps the strobe low so the second beat is a fresh request.
                if (gap_q) begin
                    gap_d = 1'b0;
                end else if (mem_resp) begin
                    beat1_d = mem_rdata;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            sz_q    <= 2'd0;
            off_q   <= '0;
            base_q  <= '0;
            wdata_q <= '0;
            split_q <= 1'b0;
            fault_q <= 1'b0;
            gap_q   <= 1'b0;
            beat0_q <= '0;
            beat1_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            sz_q    <= sz_d;
            off_q   <= off_d;
            base_q  <= base_d;
            wdata_q <= wdata_d;
            split_q <= split_d;
            fault_q <= fault_d;
            gap_q   <= gap_d;
            beat0_q <= beat0_d;
            beat1_q <= beat1_d;
        end
    end

    // Outputs are forced low for the whole reset cycle, even before the state register clears.
    always_comb begin
        req_ready       = 1'b0;
        resp_valid      = 1'b0;
        resp_rdata      = '0;
        resp_fault      = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_address     = '0;
        mem_wdata       = '0;
        mem_byte_enable = '0;
        if (!rst) begin
            req_ready = (state_q == IDLE);
            if (state_q == ACC0) begin
                mem_read        = !we_q;
                mem_write       = we_q;
                mem_address     = base_q;
                mem_byte_enable = maskWide[BYTES-1:0];
                mem_wdata       = we_q ? dataWide[XLEN-1:0] : '0;
            end else if (state_q == ACC1 && !gap_q) begin
                mem_read        = !we_q;
                mem_write       = we_q;
                mem_address     = base_q + XLEN'(BYTES);
                mem_byte_enable = maskWide[2*BYTES-1:BYTES];
                mem_wdata       = we_q ? dataWide[2*XLEN-1:XLEN] : '0;
            end else if (state_q == DONE) begin
                resp_valid = 1'b1;
                resp_fault = fault_q;
                resp_rdata = (!fault_q && !we_q) ? loadResult : '0;
            end
        end
    end

endmodule
